// File: rtl/mips32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips32_pkg
// Brief    : Opcode constants, instruction classes and small decode helpers
//            shared by the MIPS32 core and its instruction fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package mips32_pkg;

  localparam int IMEM_ADDR_W = 10;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    INSTR_RR_ALU = 3'd0,
    INSTR_RM_ALU = 3'd1,
    INSTR_LOAD   = 3'd2,
    INSTR_STORE  = 3'd3,
    INSTR_BRANCH = 3'd4,
    INSTR_HALT   = 3'd5,
    INSTR_OTHER  = 3'd6
  } instr_type_e;

  // True when the instruction word is a halt.
  function automatic logic is_hlt(input logic [31:0] ir);
    return ir[31:26] == OP_HLT;
  endfunction

  // Coarse instruction class from the opcode field.
  function automatic instr_type_e decode_type(input logic [31:0] ir);
    case (ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return INSTR_RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                      return INSTR_RM_ALU;
      OP_LW:                                          return INSTR_LOAD;
      OP_SW:                                          return INSTR_STORE;
      OP_BNEQZ, OP_BEQZ:                              return INSTR_BRANCH;
      OP_HLT:                                         return INSTR_HALT;
      default:                                        return INSTR_OTHER;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips32_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mips32_sync_fifo
// Brief    : Single-clock FIFO with push/pop/flush and occupancy count.
//            DEPTH must be a power of two so pointers wrap naturally.
// Revision : 1.0 - initial release
// ============================================================================
module mips32_sync_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));

  // Next-state for storage, pointers and count; flush discards everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty && !flush));

endmodule
`default_nettype wire

// File: rtl/mips32_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : mips32_fetch_queue
// Brief    : MIPS32 instruction fetch front end. Owns the PC, issues word
//            reads with credit-based flow control, queues {IR, NPC} for ID,
//            discards stale responses after a redirect or HLT.
// Revision : 1.0 - initial release
// ============================================================================
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int                ADDR_W   = IMEM_ADDR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk1,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_ir,
  output logic [31:0]       if_npc,
  output logic              fetch_stopped
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int QW    = 32 + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              fetch_stopped_q, fetch_stopped_d;

  logic [CNT_W-1:0]  occupancy;
  logic              q_full, q_empty;
  logic [QW-1:0]     q_head;
  logic              credit_ok, transfer, keep, q_pop;
  logic [ADDR_W-1:0] rsp_addr;
  logic              unused_bits;

  // Requests in flight plus queued words may never exceed the queue size,
  // so every response is guaranteed a slot.
  assign credit_ok = ({1'b0, occupancy} + {1'b0, outstanding_q}) < (CNT_W+1)'(DEPTH);
  assign imem_req  = rst_n & !fetch_stopped_q & !redirect_valid & credit_ok;
  assign imem_addr = pc_q;
  assign transfer  = imem_req & imem_gnt;

  // Once drop_q reaches zero every outstanding request belongs to the
  // current contiguous stream, so the oldest one sits at pc - outstanding.
  assign keep     = imem_rvalid & (drop_q == '0) & !redirect_valid;
  assign rsp_addr = pc_q - ADDR_W'(outstanding_q);
  assign q_pop    = if_valid & if_ready;

  assign if_valid      = !q_empty;
  assign if_ir         = q_empty ? 32'd0 : q_head[QW-1:ADDR_W];
  assign if_npc        = q_empty ? 32'd0 : {{(32-ADDR_W){1'b0}}, q_head[ADDR_W-1:0]};
  assign fetch_stopped = fetch_stopped_q;
  assign unused_bits   = ^redirect_pc[31:ADDR_W] ^ q_full;

  mips32_sync_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk1),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (keep),
    .push_data ({imem_rdata, rsp_addr + 1'b1}),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (occupancy)
  );

  // PC, credit, drop and halt bookkeeping; redirect overrides everything.
  always_comb begin
    pc_d            = pc_q;
    outstanding_d   = outstanding_q;
    drop_d          = drop_q;
    fetch_stopped_d = fetch_stopped_q;
    if (transfer) begin
      pc_d = pc_q + 1'b1;
    end
    case ({transfer, imem_rvalid})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
    if (imem_rvalid && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end
    if (keep && is_hlt(imem_rdata)) begin
      fetch_stopped_d = 1'b1;
      drop_d          = outstanding_d;
    end
    if (redirect_valid) begin
      pc_d            = redirect_pc[ADDR_W-1:0];
      fetch_stopped_d = 1'b0;
      drop_d          = outstanding_d;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      pc_q            <= RESET_PC;
      outstanding_q   <= '0;
      drop_q          <= '0;
      fetch_stopped_q <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      outstanding_q   <= outstanding_d;
      drop_q          <= drop_d;
      fetch_stopped_q <= fetch_stopped_d;
    end
  end

  a_outstanding_cap : assert property (@(posedge clk1) disable iff (!rst_n)
    outstanding_q <= CNT_W'(DEPTH));
  a_no_orphan_rsp : assert property (@(posedge clk1) disable iff (!rst_n)
    !(imem_rvalid && (outstanding_q == '0)));

endmodule
`default_nettype wire

// File: tb/tb_mips32_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips32_fetch_queue
// Brief    : Directed self-checking bench for the MIPS32 fetch front end,
//            with an in-order fixed-latency instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips32_fetch_queue;
  import mips32_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  logic              clk1 = 1'b0;
  logic              rst_n;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_ir;
  logic [31:0]       if_npc;
  logic              fetch_stopped;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } pend_t;

  logic [31:0] mem [1024];
  pend_t       pend [$];
  int          cyc;
  int          mem_lat;
  int          xfer_cnt;
  int          total;
  int          bad;

  always #5 clk1 = ~clk1;

  mips32_fetch_queue #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clk1           (clk1),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_ir          (if_ir),
    .if_npc         (if_npc),
    .fetch_stopped  (fetch_stopped)
  );

  // Instruction memory: records transfers mid-cycle, answers in order
  // mem_lat cycles later, forgets everything on reset.
  initial begin
    pend_t p;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    cyc         = 0;
    forever begin
      @(negedge clk1);
      if (rst_n && imem_req && imem_gnt) begin
        p.addr = imem_addr;
        p.due  = cyc + mem_lat;
        pend.push_back(p);
        xfer_cnt++;
      end
      if (!rst_n) pend.delete();
      @(posedge clk1);
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem[pend[0].addr];
        void'(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset(input int lat, input logic rdy);
    step();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    if_ready       = rdy;
    imem_gnt       = 1'b1;
    mem_lat        = lat;
    step();
    step();
    rst_n    = 1'b1;
    xfer_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    total++; if (imem_addr !== 10'd0) begin bad++; $display("FAIL reset_addr: got %h expected 000", imem_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    total++; if (if_ir !== 32'd0) begin bad++; $display("FAIL reset_ir: got %h expected 0", if_ir); end
    total++; if (if_npc !== 32'd0) begin bad++; $display("FAIL reset_npc: got %h expected 0", if_npc); end
    total++; if (fetch_stopped !== 1'b0) begin bad++; $display("FAIL reset_stopped: got %b expected 0", fetch_stopped); end
  endtask

  task automatic test_basic();
    do_reset(1, 1'b1);
    @(negedge clk1);
    total++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin
      bad++; $display("FAIL basic_first_req: got req=%b addr=%h expected req=1 addr=000", imem_req, imem_addr);
    end
    step(); @(negedge clk1);
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL basic_c1_valid: got %b expected 0", if_valid); end
    for (int k = 2; k <= 5; k++) begin
      step(); @(negedge clk1);
      total++; if (if_valid !== 1'b1 || if_ir !== mem[k-2] || if_npc !== 32'(k-1)) begin
        bad++; $display("FAIL basic_c%0d: got v=%b ir=%h npc=%h expected v=1 ir=%h npc=%h",
                        k, if_valid, if_ir, if_npc, mem[k-2], k-1);
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1, 1'b0);
    for (int k = 0; k < 9; k++) step();
    @(negedge clk1);
    total++; if (xfer_cnt !== 4) begin bad++; $display("FAIL stall_xfers: got %0d expected 4", xfer_cnt); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req_low: got %b expected 0", imem_req); end
    total++; if (if_valid !== 1'b1 || if_ir !== mem[0]) begin
      bad++; $display("FAIL stall_head: got v=%b ir=%h expected v=1 ir=%h", if_valid, if_ir, mem[0]);
    end
    step();
    if_ready = 1'b1;
    for (int k = 10; k <= 14; k++) begin
      @(negedge clk1);
      total++; if (if_valid !== 1'b1 || if_ir !== mem[k-10] || if_npc !== 32'(k-9)) begin
        bad++; $display("FAIL stall_drain_c%0d: got v=%b ir=%h npc=%h expected v=1 ir=%h npc=%h",
                        k, if_valid, if_ir, if_npc, mem[k-10], k-9);
      end
      if (k == 11) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'd4) begin
          bad++; $display("FAIL stall_resume: got req=%b addr=%h expected req=1 addr=004", imem_req, imem_addr);
        end
      end
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset(3, 1'b0);
    for (int k = 0; k < 5; k++) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    @(negedge clk1);
    total++; if (imem_req !== 1'b0 || if_valid !== 1'b1) begin
      bad++; $display("FAIL redir_cycle: got req=%b v=%b expected req=0 v=1", imem_req, if_valid);
    end
    step();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    @(negedge clk1);
    total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'h20) begin
      bad++; $display("FAIL redir_flush: got v=%b req=%b addr=%h expected v=0 req=1 addr=020",
                      if_valid, imem_req, imem_addr);
    end
    for (int k = 7; k <= 9; k++) begin
      step(); @(negedge clk1);
      total++; if (if_valid !== 1'b0) begin
        bad++; $display("FAIL redir_drop_c%0d: got v=%b ir=%h expected v=0", k, if_valid, if_ir);
      end
    end
    for (int k = 10; k <= 11; k++) begin
      step(); @(negedge clk1);
      total++; if (if_valid !== 1'b1 || if_ir !== mem[k+22] || if_npc !== 32'(k+23)) begin
        bad++; $display("FAIL redir_target_c%0d: got v=%b ir=%h npc=%h expected v=1 ir=%h npc=%h",
                        k, if_valid, if_ir, if_npc, mem[k+22], k+23);
      end
    end
  endtask

  task automatic test_hlt_and_restart();
    mem[5] = {OP_HLT, 26'd0};
    do_reset(2, 1'b1);
    for (int k = 0; k < 7; k++) step();
    @(negedge clk1);
    total++; if (fetch_stopped !== 1'b0 || if_ir !== mem[4] || if_npc !== 32'd5) begin
      bad++; $display("FAIL hlt_pre: got stop=%b ir=%h npc=%h expected stop=0 ir=%h npc=5",
                      fetch_stopped, if_ir, if_npc, mem[4]);
    end
    step(); @(negedge clk1);
    total++; if (if_valid !== 1'b1 || if_ir !== {OP_HLT, 26'd0} || if_npc !== 32'd6) begin
      bad++; $display("FAIL hlt_delivered: got v=%b ir=%h npc=%h expected v=1 ir=fc000000 npc=6",
                      if_valid, if_ir, if_npc);
    end
    total++; if (fetch_stopped !== 1'b1 || imem_req !== 1'b0) begin
      bad++; $display("FAIL hlt_stop: got stop=%b req=%b expected stop=1 req=0", fetch_stopped, imem_req);
    end
    for (int k = 9; k <= 12; k++) begin
      step(); @(negedge clk1);
      total++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
        bad++; $display("FAIL hlt_quiet_c%0d: got v=%b req=%b expected v=0 req=0", k, if_valid, imem_req);
      end
    end
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk1);
    total++; if (fetch_stopped !== 1'b1 || imem_req !== 1'b0) begin
      bad++; $display("FAIL restart_cycle: got stop=%b req=%b expected stop=1 req=0", fetch_stopped, imem_req);
    end
    step();
    redirect_valid = 1'b0;
    @(negedge clk1);
    total++; if (fetch_stopped !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'h40) begin
      bad++; $display("FAIL restart_req: got stop=%b req=%b addr=%h expected stop=0 req=1 addr=040",
                      fetch_stopped, imem_req, imem_addr);
    end
    step(); step(); step(); @(negedge clk1);
    total++; if (if_valid !== 1'b1 || if_ir !== mem[64] || if_npc !== 32'd65) begin
      bad++; $display("FAIL restart_target: got v=%b ir=%h npc=%h expected v=1 ir=%h npc=65",
                      if_valid, if_ir, if_npc, mem[64]);
    end
    mem[5] = {OP_ADDI, 10'd0, 16'd5};
  endtask

  task automatic test_midreset();
    do_reset(1, 1'b1);
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b0;
    @(negedge clk1);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL midrst_req_low: got %b expected 0", imem_req); end
    step();
    rst_n = 1'b1;
    @(negedge clk1);
    total++; if (imem_req !== 1'b1 || imem_addr !== 10'd0 || if_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_state: got req=%b addr=%h v=%b expected req=1 addr=000 v=0",
                      imem_req, imem_addr, if_valid);
    end
    total++; if (if_ir !== 32'd0 || if_npc !== 32'd0 || fetch_stopped !== 1'b0) begin
      bad++; $display("FAIL midrst_outs: got ir=%h npc=%h stop=%b expected 0 0 0", if_ir, if_npc, fetch_stopped);
    end
    step(); step(); @(negedge clk1);
    total++; if (if_valid !== 1'b1 || if_ir !== mem[0] || if_npc !== 32'd1) begin
      bad++; $display("FAIL midrst_refetch: got v=%b ir=%h npc=%h expected v=1 ir=%h npc=1",
                      if_valid, if_ir, if_npc, mem[0]);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    xfer_cnt       = 0;
    mem_lat        = 1;
    rst_n          = 1'b0;
    imem_gnt       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = {OP_ADDI, 10'd0, 16'(i)};
    mem[0] = {OP_ADD, 10'd0, 16'd0};
    mem[1] = {OP_SUB, 10'd0, 16'd1};
    mem[2] = {OP_AND, 10'd0, 16'd2};
    mem[3] = {OP_OR,  10'd0, 16'd3};

    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_hlt_and_restart();
    test_midreset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
